coffee_vend_multi: RTL

Parametrised multi-product vending controller and successor to the single-price coffee vending FSM. It accumulates coin credit and accepts a product selection against a per-product price table. It issues a one-cycle dispense pulse, then pays out change as a coin-by-coin stream under a valid/ready handshake. It also supports cancel/refund and overflow rejection, and sits between the coin acceptor front end and the dispense/change-hopper actuators.

---
 rtl/coffee_vend_multi.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/coffee_vend_multi.sv
// Multi-product coin vending controller: credit accumulation, priced
// selection, one-cycle dispense and greedy coin-by-coin change payout.
module coffee_vend_multi #(
  parameter int NUM_PROD = 4,
  parameter int PRICE_W = 8,
  parameter logic [NUM_PROD*PRICE_W-1:0] PRICES =
    {8'd15, 8'd12, 8'd10, 8'd5},
  parameter int MAX_CREDIT = 50,
  localparam int ID_W = $clog2(NUM_PROD)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               coin_valid,
  input  logic [1:0]         coin_code,
  input  logic               sel_valid,
  input  logic [ID_W-1:0]    sel_id,
  input  logic               cancel,
  input  logic               chg_ready,
  output logic [PRICE_W-1:0] credit,
  output logic [1:0]         state,
  output logic               dispense,
  output logic [ID_W-1:0]    dispense_id,
  output logic               chg_valid,
  output logic [1:0]         chg_coin,
  output logic               coin_reject,
  output logic               sel_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  state_t st, st_n;

  logic [PRICE_W-1:0] credit_n;
  logic               disp_n;
  logic [ID_W-1:0]    did_n;
  logic               cv_n;
  logic [1:0]         cc_n;
  logic               rej_n;
  logic               serr_n;

  logic [PRICE_W-1:0] price_tab [NUM_PROD];
  logic [PRICE_W-1:0] price;
  logic [PRICE_W-1:0] left;
  logic [PRICE_W:0]   sum;
  logic               over;
  logic               sel_ok;

  function automatic logic [PRICE_W-1:0] coin_val(input logic [1:0] c);
    unique case (c)
      2'd0:    coin_val = PRICE_W'(1);
      2'd1:    coin_val = PRICE_W'(2);
      2'd2:    coin_val = PRICE_W'(5);
      default: coin_val = PRICE_W'(10);
    endcase
  endfunction

  // Largest coin not exceeding v; the 1-unit coin guarantees exact payout.
  function automatic logic [1:0] pick(input logic [PRICE_W-1:0] v);
    if (v >= PRICE_W'(10))     pick = 2'd3;
    else if (v >= PRICE_W'(5)) pick = 2'd2;
    else if (v >= PRICE_W'(2)) pick = 2'd1;
    else                       pick = 2'd0;
  endfunction

  for (genvar i = 0; i < NUM_PROD; i++) begin : g_price
    assign price_tab[i] = PRICES[i*PRICE_W +: PRICE_W];
  end

  assign sel_ok = {1'b0, sel_id} < (ID_W+1)'(NUM_PROD);
  assign price  = price_tab[sel_id];
  assign sum    = {1'b0, credit} + {1'b0, coin_val(coin_code)};
  assign over   = sum > (PRICE_W+1)'(MAX_CREDIT);
  assign left   = credit - coin_val(chg_coin);
  assign state  = st;

  always_comb begin
    st_n     = st;
    credit_n = credit;
    disp_n   = 1'b0;
    did_n    = '0;
    cv_n     = 1'b0;
    cc_n     = 2'd0;
    rej_n    = 1'b0;
    serr_n   = 1'b0;
    unique case (st)
      IDLE, CREDIT: begin
        rej_n = coin_valid & (cancel | sel_valid | over);
        if (cancel) begin
          if (credit != '0) begin
            st_n = CHANGE;
            cv_n = 1'b1;
            cc_n = pick(credit);
          end else begin
            st_n = IDLE;
          end
        end else if (sel_valid) begin
          if (!sel_ok || credit < price) begin
            serr_n = 1'b1;
          end else begin
            credit_n = credit - price;
            disp_n   = 1'b1;
            did_n    = sel_id;
            st_n     = DISPENSE;
          end
        end else if (coin_valid && !over) begin
          credit_n = sum[PRICE_W-1:0];
          st_n     = CREDIT;
        end
      end
      DISPENSE: begin
        rej_n = coin_valid;
        if (credit != '0) begin
          st_n = CHANGE;
          cv_n = 1'b1;
          cc_n = pick(credit);
        end else begin
          st_n = IDLE;
        end
      end
      default: begin
        rej_n = coin_valid;
        cv_n  = 1'b1;
        cc_n  = chg_coin;
        if (chg_ready) begin
          credit_n = left;
          if (left == '0) begin
            st_n = IDLE;
            cv_n = 1'b0;
            cc_n = 2'd0;
          end else begin
            cc_n = pick(left);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= IDLE;
      credit      <= '0;
      dispense    <= 1'b0;
      dispense_id <= '0;
      chg_valid   <= 1'b0;
      chg_coin    <= 2'd0;
      coin_reject <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      st          <= st_n;
      credit      <= credit_n;
      dispense    <= disp_n;
      dispense_id <= did_n;
      chg_valid   <= cv_n;
      chg_coin    <= cc_n;
      coin_reject <= rej_n;
      sel_err     <= serr_n;
    end
  end

endmodule
